// File: rtl/lcd_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lcd_bus_pkg
// Description : Shared types and constants for the 8080-style LCD bus writer.
//               The default cycle counts are also used by the DMA / CPU-bridge
//               driver so both sides agree on strobe and reset timing.
// Revision    : 1.0  initial release
// ============================================================================
package lcd_bus_pkg;

    localparam int LCD_DW = 16;

    // Default timing at 100 MHz sysclk.
    localparam int DEF_WR_LOW_CYC   = 2;
    localparam int DEF_WR_HIGH_CYC  = 2;
    localparam int DEF_RST_LOW_CYC  = 1000;       // 10 us
    localparam int DEF_RST_WAIT_CYC = 5_000_000;  // 50 ms

    typedef enum logic [2:0] {
        S_RSTLO   = 3'd0,
        S_RSTWAIT = 3'd1,
        S_IDLE    = 3'd2,
        S_SETUP   = 3'd3,
        S_WRLO    = 3'd4,
        S_WRHI    = 3'd5
    } lcd_state_e;

    // Largest of four cycle counts; sizes the shared down-counter.
    function automatic int cyc_max(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_writer_if.sv
`default_nettype none
// ============================================================================
// Interface   : lcd_bus_writer_if
// Description : Valid/ready word stream feeding the LCD bus writer.
//               master = word producer (DMA / bridge), slave = lcd_bus_writer.
// Signals     : valid  word available
//               ready  writer accepts the word this cycle
//               data   16-bit word for lcd_data
//               rs     0 = command (index) write, 1 = data / GRAM write
// Revision    : 1.0  initial release
// ============================================================================
interface lcd_bus_writer_if;
    import lcd_bus_pkg::*;

    logic              valid;
    logic              ready;
    logic [LCD_DW-1:0] data;
    logic              rs;

    modport master (output valid, output data, output rs, input ready);
    modport slave  (input valid, input data, input rs, output ready);

endinterface
`default_nettype wire

// File: rtl/lcd_bus_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_writer
// Description : Drives an 8080-style write-only TFT bus from a valid/ready
//               word stream. Owns the panel hardware-reset sequence and the
//               write-strobe timing. One word costs 1+WR_LOW_CYC+WR_HIGH_CYC
//               cycles; back-to-back words keep cs low with no idle gap.
// Ports       : clk          system clock
//               reset        synchronous, active-high reset
//               sink         word stream (slave side)
//               ctl_hwreset  1-cycle pulse: restart the panel reset sequence
//               busy         high whenever the FSM is not idle
//               lcd_reset_n  panel reset, active-low
//               lcd_cs       chip select, active-low
//               lcd_rs       register select
//               lcd_write_n  write strobe, active-low
//               lcd_read_n   read strobe, tied high
//               lcd_data     bus data
// Revision    : 1.0  initial release
// ============================================================================
module lcd_bus_writer
    import lcd_bus_pkg::*;
#(
    parameter int WR_LOW_CYC   = DEF_WR_LOW_CYC,
    parameter int WR_HIGH_CYC  = DEF_WR_HIGH_CYC,
    parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
    parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
    input  wire logic              clk,
    input  wire logic              reset,
    lcd_bus_writer_if.slave        sink,
    input  wire logic              ctl_hwreset,
    output logic                   busy,
    output logic                   lcd_reset_n,
    output logic                   lcd_cs,
    output logic                   lcd_rs,
    output logic                   lcd_write_n,
    output logic                   lcd_read_n,
    output logic [LCD_DW-1:0]      lcd_data
);

    localparam int CNT_W = $clog2(cyc_max(WR_LOW_CYC, WR_HIGH_CYC,
                                          RST_LOW_CYC, RST_WAIT_CYC)) + 1;

    localparam logic [CNT_W-1:0] LD_RSTLO   = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RSTWAIT = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LD_WRLO    = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_WRHI    = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    lcd_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              rstn_q,  rstn_d;
    logic              cs_q,    cs_d;
    logic              rs_q,    rs_d;
    logic              wr_q,    wr_d;
    logic [LCD_DW-1:0] data_q,  data_d;

    logic cnt_zero;
    logic ready;
    logic accept;

    assign cnt_zero = (cnt_q == '0);

    // Ready in idle and in the final strobe-high cycle (which is what makes
    // bursts gapless). A hardware-reset request blocks acceptance outright.
    assign ready  = !ctl_hwreset &&
                    ((state_q == S_IDLE) || ((state_q == S_WRHI) && cnt_zero));
    assign accept = sink.valid && ready;

    assign sink.ready  = ready;
    assign busy        = (state_q != S_IDLE);
    assign lcd_reset_n = rstn_q;
    assign lcd_cs      = cs_q;
    assign lcd_rs      = rs_q;
    assign lcd_write_n = wr_q;
    assign lcd_read_n  = 1'b1;
    assign lcd_data    = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rstn_d  = rstn_q;
        cs_d    = cs_q;
        rs_d    = rs_q;
        wr_d    = wr_q;
        data_d  = data_q;

        if (ctl_hwreset) begin
            // Abort from any state; an in-flight word is simply dropped.
            state_d = S_RSTLO;
            cnt_d   = LD_RSTLO;
            rstn_d  = 1'b0;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
        end else begin
            case (state_q)
                S_RSTLO: begin
                    if (cnt_zero) begin
                        state_d = S_RSTWAIT;
                        cnt_d   = LD_RSTWAIT;
                        rstn_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_RSTWAIT: begin
                    if (cnt_zero) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        state_d = S_SETUP;
                        data_d  = sink.data;
                        rs_d    = sink.rs;
                        cs_d    = 1'b0;
                    end
                end
                S_SETUP: begin
                    state_d = S_WRLO;
                    cnt_d   = LD_WRLO;
                    wr_d    = 1'b0;
                end
                S_WRLO: begin
                    if (cnt_zero) begin
                        state_d = S_WRHI;
                        cnt_d   = LD_WRHI;
                        wr_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_WRHI: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (accept) begin
                        // Next word: cs stays low across the boundary.
                        state_d = S_SETUP;
                        data_d  = sink.data;
                        rs_d    = sink.rs;
                    end else begin
                        state_d = S_IDLE;
                        cs_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = S_RSTLO;
                    cnt_d   = LD_RSTLO;
                    rstn_d  = 1'b0;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RSTLO;
            cnt_q   <= LD_RSTLO;
            rstn_q  <= 1'b0;
            cs_q    <= 1'b1;
            rs_q    <= 1'b0;
            wr_q    <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
            cs_q    <= cs_d;
            rs_q    <= rs_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire
